// File: rtl/mac_share_arbiter.sv
// Round-robin scheduler sharing one signed Booth multiplier among NREQ requesters, each with a private accumulator.
// Optional feature macro: SATURATE_EN (saturating accumulation plus sticky sat_flag per slot).
module mac_share_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_mc,
  input  logic [NREQ*DW-1:0]      req_mp,
  input  logic [NREQ-1:0]         acc_clr,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [AW-1:0]           result,
  output logic [NREQ*AW-1:0]      acc_out,
`ifdef SATURATE_EN
  output logic [NREQ-1:0]         sat_flag,
`endif
  output logic                    sched_busy,
  output logic                    mac_start,
  output logic [DW-1:0]           mac_mc,
  output logic [DW-1:0]           mac_mp,
  input  logic                    mac_busy,
  input  logic [AW-1:0]           mac_prod
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] pick_id;
  logic           pick_found;
  logic           first_wait;
  logic [DW-1:0]  mc_hold;
  logic [DW-1:0]  mp_hold;
  logic [DW-1:0]  mc_slot [NREQ];
  logic [DW-1:0]  mp_slot [NREQ];

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign mc_slot[gi] = req_mc[gi*DW +: DW];
      assign mp_slot[gi] = req_mp[gi*DW +: DW];
    end
  endgenerate

  // Scan downward from the farthest offset so the closest request to rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rr_ptr + IDW'(k)]) begin
        pick_found = 1'b1;
        pick_id    = rr_ptr + IDW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      id_reg     <= '0;
      first_wait <= 1'b0;
      gnt        <= '0;
      mac_start  <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      result     <= '0;
      mc_hold    <= '0;
      mp_hold    <= '0;
    end else begin
      gnt       <= '0;
      mac_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            id_reg    <= pick_id;
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
            mac_start <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          mc_hold    <= mc_slot[id_reg];
          mp_hold    <= mp_slot[id_reg];
          first_wait <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // busy is stale on the first cycle after start, before the multiplier has loaded
          first_wait <= 1'b0;
          if (!first_wait && !mac_busy) begin
            result  <= mac_prod;
            done    <= 1'b1;
            done_id <= id_reg;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr <= id_reg + IDW'(1);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operands pass straight through in the grant cycle so the multiplier loads them on its start edge.
  assign mac_mc     = (state == S_LAUNCH) ? mc_slot[id_reg] : mc_hold;
  assign mac_mp     = (state == S_LAUNCH) ? mp_slot[id_reg] : mp_hold;
  assign sched_busy = (state != S_IDLE);

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_acc
      logic [AW-1:0] acc_reg;
      logic [AW-1:0] acc_sum;
      logic          owner;

      assign owner = (state == S_DONE) && (id_reg == IDW'(gi));

`ifdef SATURATE_EN
      logic [AW:0] wide;
      logic        ovf;
      logic        flag_reg;

      assign wide    = {acc_reg[AW-1], acc_reg} + {result[AW-1], result};
      assign ovf     = wide[AW] ^ wide[AW-1];
      assign acc_sum = !ovf ? wide[AW-1:0]
                     : (wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          flag_reg <= 1'b0;
        else if (acc_clr[gi])
          flag_reg <= 1'b0;
        else if (owner && ovf)
          flag_reg <= 1'b1;
      end

      assign sat_flag[gi] = flag_reg;
`else
      assign acc_sum = acc_reg + result;
`endif

      // A clear coinciding with this slot's completion restarts the sum at the new product.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          acc_reg <= '0;
        else if (acc_clr[gi])
          acc_reg <= owner ? result : '0;
        else if (owner)
          acc_reg <= acc_sum;
      end

      assign acc_out[gi*AW +: AW] = acc_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Scoreboard bench for mac_share_arbiter: directed scenarios followed by randomized request traffic,
// with a behavioural multiplier stand-in. Honours SATURATE_EN when defined.
module tb_mac_share_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_mc = '0;
  logic [31:0] req_mp = '0;
  logic [3:0]  acc_clr = '0;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic [15:0] result;
  logic [63:0] acc_out;
`ifdef SATURATE_EN
  logic [3:0]  sat_flag;
`endif
  logic        sched_busy;
  logic        mac_start;
  logic [7:0]  mac_mc;
  logic [7:0]  mac_mp;
  logic        mac_busy;
  logic [15:0] mac_prod = '0;

  always #5 clk = ~clk;

  mac_share_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_mc(req_mc),
    .req_mp(req_mp),
    .acc_clr(acc_clr),
    .gnt(gnt),
    .done(done),
    .done_id(done_id),
    .result(result),
    .acc_out(acc_out),
`ifdef SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .sched_busy(sched_busy),
    .mac_start(mac_start),
    .mac_mc(mac_mc),
    .mac_mp(mac_mp),
    .mac_busy(mac_busy),
    .mac_prod(mac_prod)
  );

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  function automatic logic [15:0] acc_add(input logic [15:0] a, input logic [15:0] p, output bit clamped);
    int s;
    s = int'($signed(a)) + int'($signed(p));
    clamped = 1'b0;
`ifdef SATURATE_EN
    if (s > 32767) begin
      s = 32767;
      clamped = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      clamped = 1'b1;
    end
`endif
    return s[15:0];
  endfunction

  // Multiplier stand-in: busy for 8 cycles after start, product valid only in the cycle busy falls.
  int         mul_cnt = 0;
  logic [7:0] mul_a = '0;
  logic [7:0] mul_b = '0;

  always @(posedge clk) begin
    if (mac_start) begin
      mul_a    <= mac_mc;
      mul_b    <= mac_mp;
      mul_cnt  <= 8;
      mac_prod <= 16'($urandom);
    end else if (mul_cnt == 1) begin
      mul_cnt  <= 0;
      mac_prod <= smul(mul_a, mul_b);
    end else begin
      if (mul_cnt > 0) mul_cnt <= mul_cnt - 1;
      mac_prod <= 16'($urandom);
    end
  end

  assign mac_busy = (mul_cnt != 0);

  // Arbitration model: decides winners from the request vector and pushes expected results.
  initial begin : model
    int         rr_m;
    int         busy_cnt;
    int         w;
    int         last_w;
    bit         found;
    logic [3:0] exp_gnt;
    exp_t       item;
    rr_m = 0;
    busy_cnt = 0;
    w = 0;
    last_w = 0;
    exp_gnt = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_result", result, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_mac_start", mac_start, 0);
        chk("rst_mac_mc", mac_mc, 0);
        chk("rst_mac_mp", mac_mp, 0);
        chk("rst_sched_busy", sched_busy, 0);
        rr_m = 0;
        busy_cnt = 0;
        exp_gnt = '0;
        sb.delete();
      end else begin
        chk("gnt", gnt, exp_gnt);
        chk("mac_start", mac_start, exp_gnt != 0);
        chk("sched_busy", sched_busy, busy_cnt > 0);
        if (exp_gnt != 0) begin
          chk("mac_mc", mac_mc, req_mc[last_w*8 +: 8]);
          chk("mac_mp", mac_mp, req_mp[last_w*8 +: 8]);
          item.id   = last_w;
          item.prod = smul(req_mc[last_w*8 +: 8], req_mp[last_w*8 +: 8]);
          item.due  = cyc + 10;
          sb.push_back(item);
        end
        exp_gnt = '0;
        if (busy_cnt > 0) begin
          busy_cnt--;
        end else if (req != 0) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if (!found && req[(rr_m + k) % 4]) begin
              found = 1'b1;
              w = (rr_m + k) % 4;
            end
          end
          exp_gnt  = 4'b0001 << w;
          last_w   = w;
          rr_m     = (w + 1) % 4;
          busy_cnt = 11;
        end
      end
    end
  end

  // Monitor: pops on done, compares results, and tracks the accumulators.
  initial begin : monitor
    logic [15:0] acc_m [4];
    bit          sat_m [4];
    exp_t        it;
    bit          have;
    bit          clamped;
    for (int i = 0; i < 4; i++) begin
      acc_m[i] = '0;
      sat_m[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 4; i++) begin
          acc_m[i] = '0;
          sat_m[i] = 1'b0;
        end
        continue;
      end
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("acc%0d", i), acc_out[i*16 +: 16], acc_m[i]);
`ifdef SATURATE_EN
        chk($sformatf("sat_flag%0d", i), sat_flag[i], sat_m[i]);
`endif
      end
      have = 1'b0;
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          it = sb.pop_front();
          have = 1'b1;
          chk("done_id", done_id, it.id);
          chk("result", result, it.prod);
          chk("done_cycle", cyc, it.due);
          $display("op done: slot %0d result %04h cycle %0d", done_id, result, cyc);
        end
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("done_missing", done, 1);
        void'(sb.pop_front());
      end
      for (int i = 0; i < 4; i++) begin
        if (acc_clr[i]) begin
          acc_m[i] = (have && it.id == i) ? it.prod : 16'h0000;
          sat_m[i] = 1'b0;
        end else if (have && it.id == i) begin
          acc_m[i] = acc_add(acc_m[i], it.prod, clamped);
          if (clamped) sat_m[i] = 1'b1;
        end
      end
    end
  end

  task automatic wait_gnt(input int s);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (gnt[s] !== 1'b1 && n < 60);
    chk($sformatf("gnt_seen%0d", s), gnt[s], 1);
  endtask

  // Returns one cycle after DONE; optionally pulses acc_clr for the slot during DONE.
  task automatic do_op(input int s, input logic [7:0] a, input logic [7:0] b, input bit clr_at_done);
    req_mc[s*8 +: 8] = a;
    req_mp[s*8 +: 8] = b;
    req[s] = 1'b1;
    wait_gnt(s);
    @(posedge clk);
    #1;
    req[s] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (clr_at_done) acc_clr[s] = 1'b1;
    @(posedge clk);
    #1;
    acc_clr[s] = 1'b0;
  endtask

  task automatic clr_pulse(input int s);
    acc_clr[s] = 1'b1;
    @(posedge clk);
    #1;
    acc_clr[s] = 1'b0;
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    int         pend [4];
    logic [3:0] prev_gnt;
    int         ids [5];
    int         exp_order [5];
    int         n;
    int         cnt;
    logic [7:0] r8;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset in the middle of WAIT aborts the operation with no done
    req_mc[7:0] = 8'd3;
    req_mp[7:0] = 8'd4;
    req[0] = 1'b1;
    wait_gnt(0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("t1_busy_in_reset", sched_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;

    do_op(0, 8'd7, 8'd6, 1'b0);
    @(negedge clk);
    chk("t2_result", result, 16'd42);
    chk("t2_acc0", acc_out[15:0], 16'd42);
    resync();

    // All four requesting: rotation continues from slot 1
    for (int i = 0; i < 4; i++) begin
      req_mc[i*8 +: 8] = 8'($urandom);
      req_mp[i*8 +: 8] = 8'($urandom);
    end
    exp_order = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) ids[k] = -1;
    req = 4'hF;
    n = 0;
    cnt = 0;
    while (n < 5 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (gnt != 0) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) ids[n] = i;
        n++;
        if (n == 5) req = 4'h0;
      end
    end
    req = 4'h0;
    for (int k = 0; k < 5; k++) chk($sformatf("t3_order%0d", k), ids[k], exp_order[k]);
    repeat (12) @(posedge clk);
    #1;

    clr_pulse(2);
    do_op(2, 8'h80, 8'h80, 1'b0);
    @(negedge clk);
    chk("t4_result_a", result, 16'h4000);
    resync();
    do_op(2, 8'hFB, 8'h03, 1'b0);
    @(negedge clk);
    chk("t4_result_b", result, 16'hFFF1);
    chk("t4_acc2", acc_out[47:32], 16'h3FF1);
    resync();

    clr_pulse(1);
    do_op(1, 8'd9, 8'd10, 1'b0);
    @(negedge clk);
    chk("t5_acc1_pre", acc_out[31:16], 16'd90);
    resync();
    do_op(1, 8'd2, 8'd5, 1'b1);
    @(negedge clk);
    chk("t5_acc1_clr_add", acc_out[31:16], 16'd10);
    resync();

    clr_pulse(3);
    do_op(3, 8'd127, 8'd127, 1'b0);
    do_op(3, 8'd127, 8'd127, 1'b0);
    do_op(3, 8'd19, 8'd26, 1'b0);
    @(negedge clk);
    chk("t6_acc3_pre", acc_out[63:48], 16'h7FF0);
    resync();
    do_op(3, 8'd10, 8'd10, 1'b0);
    @(negedge clk);
`ifdef SATURATE_EN
    chk("t6_acc3_sat", acc_out[63:48], 16'h7FFF);
    chk("t6_sat_flag3", sat_flag[3], 1);
`else
    chk("t6_acc3_wrap", acc_out[63:48], 16'h8054);
`endif
    resync();

    // Randomized traffic with arrivals, withdrawals, operand churn and clears
    for (int i = 0; i < 4; i++) pend[i] = 0;
    prev_gnt = '0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (prev_gnt[i] && pend[i] > 0) pend[i]--;
        if (!gnt[i] && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 7))
            0: r8 = 8'h80;
            1: r8 = 8'h7F;
            default: r8 = 8'($urandom);
          endcase
          req_mc[i*8 +: 8] = r8;
          req_mp[i*8 +: 8] = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
        end
        if ($urandom_range(0, 15) == 0) pend[i] += $urandom_range(1, 3);
        if (!gnt[i] && $urandom_range(0, 63) == 0) pend[i] = 0;
        req[i] = (pend[i] > 0);
        acc_clr[i] = ($urandom_range(0, 31) == 0);
      end
      prev_gnt = gnt;
    end
    req = '0;
    acc_clr = '0;

    n = 0;
    while ((sb.size() != 0 || sched_busy) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    chk("drain_pending", sb.size(), 0);
    chk("drain_idle", sched_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
